bg_priority_sequencer: RTL and testbench

//  Per-pixel BG layer resolver. Drives the select of the 4:1 BG pixel mux and consumes its output.

---
 rtl/bg_priority_sequencer.sv | 133 +++++++++++++
 tb/tb_bg_priority_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bg_priority_sequencer.sv
// Per-pixel BG layer resolver: scans enabled layers in priority order via a 4:1 mux.
// Define BG_SEQ_EARLY_EXIT_EN to stop scanning at the first opaque pixel.
module bg_priority_sequencer #(
    parameter int WIDTH      = 16,
    parameter int OPAQUE_BIT = 15,
    parameter int COLOR_W    = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         bg_enable,
    input  logic [7:0]         bg_prio,
    input  logic [COLOR_W-1:0] backdrop,
    output logic [1:0]         mux_sel,
    input  logic [WIDTH-1:0]   mux_y,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COLOR_W-1:0] pix_color,
    output logic [2:0]         pix_layer
);

    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

    state_t state, state_nx;

    logic [3:0][1:0]     rank;
    logic [3:0][1:0]     order_c;
    logic [3:0][1:0]     order_q;
    logic [2:0]          n_c;
    logic [2:0]          n_q;
    logic [1:0]          idx;
    logic [1:0]          sel_q;
    logic [1:0]          cur;
    logic [COLOR_W-1:0]  bd_q;
    logic                found;
    logic                hit;
    logic                last;
    logic                done;
    logic                accept;

    // Rank of layer i = enabled layers that beat it (lower prio, or equal prio and lower index)
    always_comb begin
        rank = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (bg_enable[j] &&
                    ((bg_prio[2*j +: 2] < bg_prio[2*i +: 2]) ||
                     ((bg_prio[2*j +: 2] == bg_prio[2*i +: 2]) && (j < i))))
                    rank[i] = rank[i] + 2'd1;
            end
        end
    end

    always_comb begin
        order_c = '0;
        n_c     = '0;
        for (int i = 0; i < 4; i++) begin
            if (bg_enable[i]) begin
                order_c[rank[i]] = 2'(i);
                n_c = n_c + 3'd1;
            end
        end
    end

    assign accept = in_valid && (state == IDLE);
    assign cur    = order_q[idx];
    assign hit    = mux_y[OPAQUE_BIT];
    assign last   = ({1'b0, idx} == (n_q - 3'd1));

`ifdef BG_SEQ_EARLY_EXIT_EN
    assign done = hit || last;
`else
    assign done = last;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = (n_c == 3'd0) ? OUT : SCAN;
            SCAN: if (done) state_nx = OUT;
            OUT:  if (pix_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        pix_valid = (state == OUT);
        mux_sel   = (state == SCAN) ? cur : sel_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            order_q   <= '0;
            n_q       <= '0;
            bd_q      <= '0;
            idx       <= '0;
            sel_q     <= '0;
            found     <= 1'b0;
            pix_color <= '0;
            pix_layer <= '0;
        end else if (accept) begin
            order_q <= order_c;
            n_q     <= n_c;
            bd_q    <= backdrop;
            idx     <= '0;
            found   <= 1'b0;
            if (n_c == 3'd0) begin
                pix_color <= backdrop;
                pix_layer <= 3'd4;
            end
        end else if (state == SCAN) begin
            sel_q <= cur;
            if (!done) idx <= idx + 2'd1;
            // First hit wins; later hits in a full scan are ignored
            if (hit && !found) begin
                found     <= 1'b1;
                pix_color <= mux_y[COLOR_W-1:0];
                pix_layer <= {1'b0, cur};
            end else if (last && !found) begin
                pix_color <= bd_q;
                pix_layer <= 3'd4;
            end
        end
    end

endmodule

// File: tb/tb_bg_priority_sequencer.sv
// Randomized bench for bg_priority_sequencer against a queue-based reference model.
// Honors BG_SEQ_EARLY_EXIT_EN for expected latency.
module tb_bg_priority_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  bg_enable;
    logic [7:0]  bg_prio;
    logic [14:0] backdrop;
    logic [1:0]  mux_sel;
    logic [15:0] mux_y;
    logic        pix_valid;
    logic        pix_ready;
    logic [14:0] pix_color;
    logic [2:0]  pix_layer;

    logic [15:0] px [4];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign mux_y = px[mux_sel];

    bg_priority_sequencer dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .bg_enable(bg_enable),
        .bg_prio(bg_prio),
        .backdrop(backdrop),
        .mux_sel(mux_sel),
        .mux_y(mux_y),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_color(pix_color),
        .pix_layer(pix_layer)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        bg_enable = 4'($urandom);
        bg_prio   = 8'($urandom);
        backdrop  = 15'($urandom);
    endtask

    task automatic run_px(input logic [3:0] en, input logic [7:0] pr,
                          input logic [14:0] bd, input int stall);
        int ord[$];
        int sels[$];
        int n, k, lat, got_lat;
        logic [14:0] exp_col;
        int exp_lay;
        // Reference: bucket by priority value, then by index
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 4; i++)
                if (en[i] && int'(pr[2*i +: 2]) == p) ord.push_back(i);
        n = ord.size();
        k = 0;
        exp_col = bd;
        exp_lay = 4;
        for (int j = 0; j < n; j++) begin
            if (k == 0 && px[ord[j]][15]) begin
                k = j + 1;
                exp_col = px[ord[j]][14:0];
                exp_lay = ord[j];
            end
        end
`ifdef BG_SEQ_EARLY_EXIT_EN
        lat = (n == 0) ? 1 : ((k > 0) ? k + 1 : n + 1);
`else
        lat = n + 1;
`endif
        @(negedge clock);
        chk("in_ready_idle", in_ready, 1);
        bg_enable = en;
        bg_prio   = pr;
        backdrop  = bd;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        scramble();
        got_lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (pix_valid) begin
                got_lat = c;
                break;
            end
            sels.push_back(int'(mux_sel));
            scramble();
        end
        chk("latency", got_lat, lat);
        if (got_lat == 0) return;
        chk("nsel", sels.size(), lat - 1);
        for (int j = 0; j < sels.size() && j < n; j++)
            chk("mux_sel", sels[j], ord[j]);
        chk("color", pix_color, exp_col);
        chk("layer", pix_layer, exp_lay);
        chk("in_ready_busy", in_ready, 0);
        for (int s = 0; s < stall; s++) begin
            scramble();
            @(negedge clock);
            chk("stall_valid", pix_valid, 1);
            chk("stall_color", pix_color, exp_col);
            chk("stall_layer", pix_layer, exp_lay);
            chk("stall_ready", in_ready, 0);
            if (n > 0) chk("sel_hold", mux_sel, ord[lat-2]);
        end
        pix_ready = 1'b1;
        @(posedge clock);
        #1;
        pix_ready = 1'b0;
    endtask

    task automatic reset_mid_scan();
        for (int i = 0; i < 4; i++) px[i] = 16'h0123;
        @(negedge clock);
        bg_enable = 4'hF;
        bg_prio   = 8'h00;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        chk("rst_in_scan", pix_valid, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", in_ready, 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            chk("rst_no_valid", pix_valid, 0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        pix_ready = 1'b0;
        bg_enable = '0;
        bg_prio   = '0;
        backdrop  = '0;
        for (int i = 0; i < 4; i++) px[i] = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_color", pix_color, 0);
        chk("rst_pix_layer", pix_layer, 0);
        chk("rst_mux_sel", mux_sel, 0);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 4; i++) px[i] = 16'h8000 | 16'(i * 16'h111);
        run_px(4'hF, 8'b11_10_01_00, 15'h1234, 1);

        run_px(4'h0, 8'h00, 15'h7C1F, 0);

        px[1] = 16'h801F;
        px[2] = 16'h7FFF;
        run_px(4'b0110, 8'b00_01_10_00, 15'h0AAA, 0);

        for (int i = 0; i < 3; i++) px[i] = 16'h7ABC;
        px[3] = 16'h8F0F;
        run_px(4'hF, 8'h00, 15'h0001, 0);

        for (int i = 0; i < 4; i++) px[i] = 16'h0000;
        px[0] = 16'h8555;
        px[3] = 16'h8333;
        run_px(4'b1001, 8'b00_00_00_11, 15'h0002, 10);

        reset_mid_scan();
        px[2] = 16'h8444;
        run_px(4'b0100, 8'h00, 15'h0003, 0);

        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 4; i++)
                px[i] = {($urandom_range(0, 9) < 4), 15'($urandom)};
            run_px(4'($urandom), 8'($urandom), 15'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
